// File: rtl/afifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : afifo_pkg
// Purpose  : Shared types and constants for the asynchronous FIFO and its
//            read-side drain controller.
// Revision : 1.0  initial release
// ============================================================================
package afifo_pkg;

  // FIFO data word
  localparam int DATA_W = 8;
  typedef logic [DATA_W-1:0] data_ty;

  // Read-side skid buffer depth (covers one cycle of FIFO read latency)
  localparam int RD_BUF_DEPTH = 2;

  // Read drain controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/afifo_if.sv
`default_nettype none
// ============================================================================
// Module   : afifo_if
// Purpose  : FIFO read port plus downstream valid/ready stream.
//            master = drain controller view, slave = its environment,
//            fifo = the FIFO's own read-port view.
// Revision : 1.0  initial release
// ============================================================================
interface afifo_if;
  import afifo_pkg::*;

  logic   pop;
  logic   empty;
  data_ty data_out;
  logic   m_valid;
  logic   m_ready;
  data_ty m_data;

  modport fifo   (input pop, output empty, output data_out);

  modport master (output pop, input empty, input data_out,
                  output m_valid, input m_ready, output m_data);

  modport slave  (input pop, output empty, output data_out,
                  input m_valid, output m_ready, input m_data);

endinterface
`default_nettype wire

// File: rtl/afifo_rd_skid.sv
`default_nettype none
// ============================================================================
// Module   : afifo_rd_skid
// Purpose  : Two-entry FIFO-ordered buffer. head is the oldest entry;
//            a write and a dequeue in the same cycle keep occupancy constant.
// Revision : 1.0  initial release
// ============================================================================
module afifo_rd_skid
  import afifo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             deq,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] r_mem [RD_BUF_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_occ;

  // Storage: write into the slot at the write pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_BUF_DEPTH; i++) r_mem[i] <= '0;
    end else if (wr_en) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (wr_en) r_wr_ptr <= ~r_wr_ptr;
      if (deq)   r_rd_ptr <= ~r_rd_ptr;
      case ({wr_en, deq})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign occ  = r_occ;
  assign head = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/afifo_rd_drain.sv
`default_nettype none
// ============================================================================
// Module   : afifo_rd_drain
// Purpose  : Read-domain drain controller. Pops the async FIFO while data is
//            available and buffer room exists, absorbs the one-cycle read
//            latency in a 2-entry skid buffer and presents a valid/ready
//            stream downstream. Counts pops since reset.
// Revision : 1.0  initial release
// ============================================================================
module afifo_rd_drain
  import afifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk_read,
  input  logic             rd_rst,
  input  logic             en,
  afifo_if.master          bus,
  output logic             busy,
  output logic [CNT_W-1:0] pop_cnt
);

  rd_state_e        r_state;
  rd_state_e        w_state_nxt;
  logic             r_infl;
  logic [CNT_W-1:0] r_pop_cnt;
  logic [1:0]       w_occ;
  logic [WIDTH-1:0] w_head;
  logic             w_deq;
  logic             w_room;
  logic             w_pop;

  assign w_deq = bus.m_valid & bus.m_ready;

  // Room test (occ + infl - deq) < 2, rearranged to avoid underflow
  assign w_room = ({1'b0, w_occ} + {2'b0, r_infl}) < (3'd2 + {2'b0, w_deq});

  // State register
  always_ff @(posedge clk_read or posedge rd_rst) begin
    if (rd_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (en) w_state_nxt = ACTIVE;
      ACTIVE:  if (!en) w_state_nxt = DRAIN;
      DRAIN: begin
        if (en)                          w_state_nxt = ACTIVE;
        else if (!r_infl && w_occ == 2'd0) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs: pop strobe, stream side, busy
  always_comb begin
    w_pop       = !rd_rst && (r_state == ACTIVE) && !bus.empty && w_room;
    bus.pop     = w_pop;
    bus.m_valid = (w_occ != 2'd0);
    bus.m_data  = w_head;
    busy        = (r_state != IDLE);
  end

  // In-flight flag: read data arrives the cycle after a pop
  always_ff @(posedge clk_read or posedge rd_rst) begin
    if (rd_rst) r_infl <= 1'b0;
    else        r_infl <= w_pop;
  end

  // Pop counter, wraps naturally
  always_ff @(posedge clk_read or posedge rd_rst) begin
    if (rd_rst)     r_pop_cnt <= '0;
    else if (w_pop) r_pop_cnt <= r_pop_cnt + 1'b1;
  end

  assign pop_cnt = r_pop_cnt;

  afifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
    .clk     (clk_read),
    .rst     (rd_rst),
    .wr_en   (r_infl),
    .wr_data (bus.data_out),
    .deq     (w_deq),
    .occ     (w_occ),
    .head    (w_head)
  );

endmodule
`default_nettype wire

// File: tb/tb_afifo_rd_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_afifo_rd_drain
// Purpose  : Self-checking bench: FIFO environment, queue-level reference
//            model compared every cycle, plus directed literal checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_afifo_rd_drain;
  import afifo_pkg::*;

  localparam int CW = 4;

  logic          clk_read = 1'b0;
  logic          rd_rst   = 1'b1;
  logic          en       = 1'b0;
  logic          busy;
  logic [CW-1:0] pop_cnt;

  afifo_if bus();

  afifo_rd_drain #(.WIDTH(8), .CNT_W(CW)) dut (
    .clk_read (clk_read),
    .rd_rst   (rd_rst),
    .en       (en),
    .bus      (bus),
    .busy     (busy),
    .pop_cnt  (pop_cnt)
  );

  always #5 clk_read = ~clk_read;

  int total = 0;
  int bad   = 0;

  // environment FIFO contents
  data_ty env_q[$];
  // reference model: buffered words, in-flight word, state, pop count
  data_ty m_buf[$];
  bit     m_infl;
  data_ty m_infl_word;
  int     m_st;          // 0 idle, 1 active, 2 drain
  int     m_cnt;
  // observation logs
  int     cyc;
  int     pops_seen;
  int     vld_seen;
  int     first_pop_cyc;
  int     first_dlv_cyc;
  data_ty got[$];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_buf.delete();
    m_infl = 1'b0;
    m_st   = 0;
    m_cnt  = 0;
  endtask

  // One clock cycle; entered and left at a falling edge with inputs set.
  task automatic step();
    bit     e_val, e_deq, e_pop, a_pop;
    int     nst;
    data_ty w;
    bus.empty = (env_q.size() == 0);
    #1;
    e_val = (m_buf.size() != 0);
    e_deq = e_val && bus.m_ready;
    e_pop = !rd_rst && m_st == 1 && env_q.size() != 0 &&
            (int'(m_buf.size()) + int'(m_infl) - int'(e_deq) < 2);
    check("pop", int'(bus.pop), int'(e_pop));
    check("m_valid", int'(bus.m_valid), int'(e_val));
    if (e_val) check("m_data", int'(bus.m_data), int'(m_buf[0]));
    check("busy", int'(busy), int'(m_st != 0));
    check("pop_cnt", int'(pop_cnt), m_cnt % (1 << CW));
    check("no_underflow", int'(bus.pop && bus.empty), 0);
    a_pop = bus.pop;
    if (a_pop) begin
      if (pops_seen == 0) first_pop_cyc = cyc;
      pops_seen++;
    end
    if (bus.m_valid) vld_seen++;
    if (bus.m_valid && bus.m_ready) begin
      if (got.size() == 0) first_dlv_cyc = cyc;
      got.push_back(bus.m_data);
    end
    @(posedge clk_read);
    #1;
    w = (env_q.size() != 0) ? env_q[0] : '0;
    if (a_pop && env_q.size() != 0) bus.data_out = env_q.pop_front();
    if (!rd_rst) begin
      nst = m_st;
      if (m_st == 0 && en) nst = 1;
      else if (m_st == 1 && !en) nst = 2;
      else if (m_st == 2) begin
        if (en) nst = 1;
        else if (!m_infl && m_buf.size() == 0) nst = 0;
      end
      if (e_deq) void'(m_buf.pop_front());
      if (m_infl) m_buf.push_back(m_infl_word);
      m_infl = e_pop;
      if (e_pop) m_infl_word = w;
      if (e_pop) m_cnt++;
      m_st = nst;
    end
    cyc++;
    @(negedge clk_read);
  endtask

  task automatic clear_logs();
    pops_seen = 0;
    vld_seen  = 0;
    got.delete();
  endtask

  initial begin
    int b0;
    bit reached;
    bus.empty    = 1'b1;
    bus.data_out = '0;
    bus.m_ready  = 1'b0;
    cyc = 0;
    model_reset();
    clear_logs();

    // ---------------- reset values
    @(negedge clk_read);
    @(negedge clk_read);
    check("rst_pop", int'(bus.pop), 0);
    check("rst_m_valid", int'(bus.m_valid), 0);
    check("rst_m_data", int'(bus.m_data), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pop_cnt", int'(pop_cnt), 0);
    rd_rst = 1'b0;

    // ---------------- basic transfer
    env_q = '{8'h11, 8'h22, 8'h33};
    en = 1'b1;
    bus.m_ready = 1'b1;
    clear_logs();
    repeat (8) step();
    check("basic_pops", pops_seen, 3);
    check("basic_ndata", got.size(), 3);
    if (got.size() == 3) begin
      check("basic_d0", int'(got[0]), 'h11);
      check("basic_d1", int'(got[1]), 'h22);
      check("basic_d2", int'(got[2]), 'h33);
    end
    check("basic_latency", first_dlv_cyc - first_pop_cyc, 2);
    check("basic_cnt", int'(pop_cnt), 3);

    // ---------------- backpressure
    bus.m_ready = 1'b0;
    env_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    clear_logs();
    repeat (4) step();
    for (int i = 0; i < 6; i++) begin
      check("bp_hold_valid", int'(bus.m_valid), 1);
      check("bp_hold_data", int'(bus.m_data), 'hA0);
      step();
    end
    check("bp_pops_stalled", pops_seen, 2);
    bus.m_ready = 1'b1;
    repeat (10) step();
    check("bp_pops_total", pops_seen, 4);
    check("bp_ndata", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      check("bp_order", int'(got[i]), 'hA0 + i);

    // ---------------- empty boundary
    env_q = '{8'h5C};
    clear_logs();
    repeat (6) step();
    check("eb_pops", pops_seen, 1);
    check("eb_valid_cycles", vld_seen, 1);
    check("eb_data", (got.size() == 1) ? int'(got[0]) : -1, 'h5C);

    // ---------------- drain
    env_q = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68};
    clear_logs();
    reached = 1'b0;
    for (int i = 0; i < 10 && !reached; i++) begin
      b0 = pops_seen;
      step();
      if (pops_seen != b0) reached = 1'b1;
    end
    check("drain_pop_seen", int'(reached), 1);
    en = 1'b0;
    step();
    b0 = pops_seen;
    repeat (8) step();
    check("drain_no_pops", pops_seen - b0, 0);
    check("drain_delivered", got.size(), pops_seen);
    check("drain_busy", int'(busy), 0);
    check("drain_fifo_left", int'(env_q.size() != 0), 1);

    // ---------------- mid-transfer reset
    env_q.delete();
    for (int i = 0; i < 5; i++) env_q.push_back(8'h70 + 8'(i));
    en = 1'b1;
    bus.m_ready = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (m_infl && m_buf.size() == 1) reached = 1'b1;
      else step();
    end
    check("mr_reached", int'(reached), 1);
    check("mr_pre_valid", int'(bus.m_valid), 1);
    rd_rst = 1'b1;
    #1;
    check("mr_m_valid", int'(bus.m_valid), 0);
    check("mr_pop", int'(bus.pop), 0);
    check("mr_pop_cnt", int'(pop_cnt), 0);
    check("mr_busy", int'(busy), 0);
    model_reset();
    env_q.delete();
    bus.empty = 1'b1;
    @(negedge clk_read);
    @(negedge clk_read);
    rd_rst = 1'b0;

    // ---------------- counter wrap
    bus.m_ready = 1'b1;
    for (int i = 0; i < 17; i++) env_q.push_back(8'(i + 1));
    clear_logs();
    repeat (26) step();
    check("wrap_pops", pops_seen, 17);
    check("wrap_cnt", int'(pop_cnt), 1);

    // ---------------- randomized traffic
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) != 0);
      bus.m_ready = ($urandom_range(0, 2) != 0);
      if (env_q.size() < 8 && $urandom_range(0, 1) == 1)
        env_q.push_back(8'($urandom));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
